sync_fifo_buffer: RTL and testbench

Parametrised single-clock FIFO buffer carrying 16-bit (default) words from a producer (Fibonacci or Timer module) to a consumer.
- Generalises the earlier 8-entry buffer: configurable width, depth and almost-full/almost-empty thresholds.
- Adds an occupancy count, an explicit read handshake and sticky overflow/underflow error flags.
- Sits between the producer and the display/consumer path; buffer_full is the back-pressure signal the producer must honour.

---
 rtl/sync_fifo_pkg.sv | 19 +
 rtl/sync_fifo_buffer_if.sv | 39 +++
 rtl/sync_fifo_buffer_fifo_ram.sv | 45 ++++
 rtl/sync_fifo_buffer.sv | 116 +++++++++++
 tb/tb_sync_fifo_buffer.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared constants, count-width helper and status bundle for sync_fifo_buffer
package sync_fifo_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 8;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
  } fifo_status_t;

  // Occupancy needs one extra bit so that DEPTH itself is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_buffer_if.sv
// rtl/sync_fifo_buffer_if.sv - producer/consumer handshake and status bundle for sync_fifo_buffer
interface sync_fifo_buffer_if
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
);

  localparam int CNT_W = cnt_width(DEPTH);

  logic              data_1_en;
  logic [DATA_W-1:0] data_1;
  logic              data_2_rd;
  logic              flag_clr;
  logic [DATA_W-1:0] data_2;
  logic              data_2_valid;
  logic              buffer_empty;
  logic              buffer_full;
  logic              buffer_almost_full;
  logic              buffer_almost_empty;
  logic [CNT_W-1:0]  buffer_count;
  logic              overflow;
  logic              underflow;

  modport slave (
    input  data_1_en, data_1, data_2_rd, flag_clr,
    output data_2, data_2_valid, buffer_empty, buffer_full,
           buffer_almost_full, buffer_almost_empty, buffer_count,
           overflow, underflow
  );

  modport master (
    output data_1_en, data_1, data_2_rd, flag_clr,
    input  data_2, data_2_valid, buffer_empty, buffer_full,
           buffer_almost_full, buffer_almost_empty, buffer_count,
           overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_buffer_fifo_ram.sv
// rtl/sync_fifo_buffer_fifo_ram.sv - DEPTH x DATA_W storage, one sync write port, one read port
// Read port is combinational when SYNC_FIFO_FWFT_EN is defined, registered otherwise.
module fifo_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  logic w_unused;
  assign w_unused = &{1'b0, i_re, i_rst};
  assign o_rdata  = r_mem[i_raddr];
`else
  logic [DATA_W-1:0] r_rdata;

  // Output register holds the last popped word between reads.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;
`endif

endmodule

// File: rtl/sync_fifo_buffer.sv
// rtl/sync_fifo_buffer.sv - single-clock FIFO with occupancy count, threshold flags and sticky errors
// Define SYNC_FIFO_FWFT_EN for first-word fall-through reads; default is 1-cycle registered read.
module sync_fifo_buffer
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk_1,
  input  logic              rst,
  sync_fifo_buffer_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = cnt_width(DEPTH);

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;
  logic              r_underflow;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [DATA_W-1:0] w_rdata;
  fifo_status_t      w_status;

  // All status decodes from the registered count only, so flags never glitch.
  assign w_status.empty        = (r_count == '0);
  assign w_status.full         = (r_count == CNT_W'(DEPTH));
  assign w_status.almost_full  = (r_count >= CNT_W'(AF_LEVEL));
  assign w_status.almost_empty = (r_count <= CNT_W'(AE_LEVEL));

  assign w_wr_acc = bus.data_1_en && !w_status.full;
  assign w_rd_acc = bus.data_2_rd && !w_status.empty;

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A new error in the same cycle as flag_clr keeps the flag set.
  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (bus.data_1_en && w_status.full) begin
        r_overflow <= 1'b1;
      end else if (bus.flag_clr) begin
        r_overflow <= 1'b0;
      end
      if (bus.data_2_rd && w_status.empty) begin
        r_underflow <= 1'b1;
      end else if (bus.flag_clr) begin
        r_underflow <= 1'b0;
      end
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .i_clk   (clk_1),
    .i_rst   (rst),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.data_1),
    .i_re    (w_rd_acc),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  assign bus.data_2_valid = !w_status.empty;
`else
  logic r_data_2_valid;

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      r_data_2_valid <= 1'b0;
    end else begin
      r_data_2_valid <= w_rd_acc;
    end
  end

  assign bus.data_2_valid = r_data_2_valid;
`endif

  assign bus.data_2              = w_rdata;
  assign bus.buffer_empty        = w_status.empty;
  assign bus.buffer_full         = w_status.full;
  assign bus.buffer_almost_full  = w_status.almost_full;
  assign bus.buffer_almost_empty = w_status.almost_empty;
  assign bus.buffer_count        = r_count;
  assign bus.overflow            = r_overflow;
  assign bus.underflow           = r_underflow;

endmodule

// File: tb/tb_sync_fifo_buffer.sv
// tb/tb_sync_fifo_buffer.sv - directed plus random bench for sync_fifo_buffer against a queue model
// Follows SYNC_FIFO_FWFT_EN so the same bench covers both read modes.
module tb_sync_fifo_buffer;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int AF     = 6;
  localparam int AE     = 2;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] m_data;
  bit                m_valid;
  bit                m_ovf;
  bit                m_udf;

  sync_fifo_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  sync_fifo_buffer #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk_1 (clk),
    .rst   (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_data  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    int n;
    n = q.size();
    chk({tag, ".count"}, 32'(bus.buffer_count), 32'(n));
    chk({tag, ".empty"}, 32'(bus.buffer_empty), 32'(n == 0));
    chk({tag, ".full"}, 32'(bus.buffer_full), 32'(n == DEPTH));
    chk({tag, ".afull"}, 32'(bus.buffer_almost_full), 32'(n >= AF));
    chk({tag, ".aempty"}, 32'(bus.buffer_almost_empty), 32'(n <= AE));
    chk({tag, ".ovf"}, 32'(bus.overflow), 32'(m_ovf));
    chk({tag, ".udf"}, 32'(bus.underflow), 32'(m_udf));
`ifdef SYNC_FIFO_FWFT_EN
    chk({tag, ".valid"}, 32'(bus.data_2_valid), 32'(n != 0));
    if (n != 0) chk({tag, ".data"}, 32'(bus.data_2), 32'(q[0]));
`else
    chk({tag, ".valid"}, 32'(bus.data_2_valid), 32'(m_valid));
    chk({tag, ".data"}, 32'(bus.data_2), 32'(m_data));
`endif
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic step(input string tag, input bit en, input logic [DATA_W-1:0] d,
                      input bit rd, input bit clr);
    bit full, empty, wok, rok;
    logic [DATA_W-1:0] popped;
    bus.data_1_en = en;
    bus.data_1    = d;
    bus.data_2_rd = rd;
    bus.flag_clr  = clr;
    full  = (q.size() == DEPTH);
    empty = (q.size() == 0);
    wok   = en && !full;
    rok   = rd && !empty;
    @(posedge clk);
    #1;
    m_valid = rok;
    if (rok) begin
      popped = q.pop_front();
      m_data = popped;
    end
    if (wok) q.push_back(d);
    if (en && full) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (rd && empty) m_udf = 1'b1;
    else if (clr) m_udf = 1'b0;
    check_outputs(tag);
  endtask

  task automatic idle_inputs();
    bus.data_1_en = 1'b0;
    bus.data_1    = '0;
    bus.data_2_rd = 1'b0;
    bus.flag_clr  = 1'b0;
  endtask

  logic [DATA_W-1:0] wrap_val;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle_inputs();
    model_reset();
    rst = 1'b1;
    #1;
    check_outputs("por");
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;

    // Asynchronous reset in the middle of a write with five words stored.
    for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, DATA_W'(16'h100 + i), 1'b0, 1'b0);
    bus.data_1_en = 1'b1;
    bus.data_1    = 16'h5555;
    #3 rst = 1'b1;
    #1;
    model_reset();
    chk("arst.count", 32'(bus.buffer_count), 32'd0);
    chk("arst.empty", 32'(bus.buffer_empty), 32'd1);
    chk("arst.valid", 32'(bus.data_2_valid), 32'd0);
    chk("arst.ovf", 32'(bus.overflow), 32'd0);
    chk("arst.udf", 32'(bus.underflow), 32'd0);
    idle_inputs();
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check_outputs("arst_rel");

    // Fill past full, then drain past empty.
    for (int i = 1; i <= 9; i++) step("fill", 1'b1, DATA_W'(i), 1'b0, 1'b0);
    chk("fill.count8", 32'(bus.buffer_count), 32'd8);
    chk("fill.ovf", 32'(bus.overflow), 32'd1);
    for (int i = 1; i <= 9; i++) step("drain", 1'b0, '0, 1'b1, 1'b0);
    chk("drain.udf", 32'(bus.underflow), 32'd1);
    chk("drain.valid0", 32'(bus.data_2_valid), 32'd0);

    // Write and read together while empty: write lands, read is an underflow.
    step("clr", 1'b0, '0, 1'b0, 1'b1);
    step("empty_wr_rd", 1'b1, 16'hA001, 1'b1, 1'b0);
    chk("empty_wr_rd.count1", 32'(bus.buffer_count), 32'd1);
    chk("empty_wr_rd.udf", 32'(bus.underflow), 32'd1);

    for (int i = 0; i < 3; i++) step("to4", 1'b1, DATA_W'(16'hA002 + i), 1'b0, 1'b0);
    step("four_wr_rd", 1'b1, 16'hA010, 1'b1, 1'b0);
    chk("four_wr_rd.count4", 32'(bus.buffer_count), 32'd4);

    for (int i = 0; i < 4; i++) step("to8", 1'b1, DATA_W'(16'hA020 + i), 1'b0, 1'b0);
    step("clr2", 1'b0, '0, 1'b0, 1'b1);
    step("full_wr_rd", 1'b1, 16'hDEAD, 1'b1, 1'b0);
    chk("full_wr_rd.count7", 32'(bus.buffer_count), 32'd7);
    chk("full_wr_rd.ovf", 32'(bus.overflow), 32'd1);

    // Error set and clear in the same cycle: set wins.
    step("fill8", 1'b1, 16'hA030, 1'b0, 1'b0);
    step("set_wins", 1'b1, 16'hA031, 1'b0, 1'b1);
    chk("set_wins.ovf", 32'(bus.overflow), 32'd1);

    while (q.size() != 0) step("drain2", 1'b0, '0, 1'b1, 1'b0);
    step("clr3", 1'b0, '0, 1'b0, 1'b1);

    // Write 3 / read 3 wraps both pointers twice.
    wrap_val = 16'h3000;
    for (int it = 0; it < 5; it++) begin
      for (int k = 0; k < 3; k++) begin
        step("wrap_wr", 1'b1, wrap_val, 1'b0, 1'b0);
        wrap_val++;
      end
      for (int k = 0; k < 3; k++) step("wrap_rd", 1'b0, '0, 1'b1, 1'b0);
    end

`ifdef SYNC_FIFO_FWFT_EN
    step("fwft_wr", 1'b1, 16'hBEEF, 1'b0, 1'b0);
    chk("fwft.data", 32'(bus.data_2), 32'h0000BEEF);
    chk("fwft.valid", 32'(bus.data_2_valid), 32'd1);
    step("fwft_pop", 1'b0, '0, 1'b1, 1'b0);
    chk("fwft.empty", 32'(bus.buffer_empty), 32'd1);
`endif

    // Random traffic with biased mixes so both full and empty are visited.
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 200; i++) begin
        int wp;
        wp = (ph == 0) ? 75 : (ph == 1) ? 25 : 50;
        step("rand", ($urandom_range(0, 99) < wp), DATA_W'($urandom),
             ($urandom_range(0, 99) < (100 - wp)), ($urandom_range(0, 99) < 8));
      end
    end

    idle_inputs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
